// File: rtl/byte_stream_tx.sv
// Serialises WORD_BYTES-wide words onto an 8-bit line, LSB first. The first byte follows acceptance by one cycle,
// and tx_done fires DRAIN cycles after the last byte. s_ready drops during a word and during drain; only the final byte slot may reload.
module byte_stream_tx #(
  parameter int WORD_BYTES = 4,
  parameter int DRAIN      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*WORD_BYTES-1:0] s_data,
  input  logic                    s_last,
  output logic [7:0]              tx_data,
  output logic                    tx_en_n,
  output logic                    tx_done,
  output logic                    busy
);

  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_BYTES - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DRAIN);
  localparam logic [DW-1:0] DCNT_PRE  = DW'(DRAIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [DW-1:0]           r_dcnt;
  logic                    r_last;
  logic [8*WORD_BYTES-1:0] r_word;
  logic [7:0]              r_tx_data;
  logic                    r_tx_en_n;
  logic                    r_tx_done;
  logic                    r_busy;
  logic                    w_ready;
  logic                    w_accept;

  // Ready comes from registered state only; rst_n gates it so nothing is taken during reset.
  assign w_ready  = rst_n && ((r_state == S_IDLE) ||
                    ((r_state == S_SEND) && (r_cnt == CNT_LAST) && !r_last));
  assign w_accept = s_valid && w_ready;

  assign s_ready = w_ready;
  assign tx_data = r_tx_data;
  assign tx_en_n = r_tx_en_n;
  assign tx_done = r_tx_done;
  assign busy    = r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dcnt    <= '0;
      r_last    <= 1'b0;
      r_word    <= '0;
      r_tx_data <= 8'h00;
      r_tx_en_n <= 1'b1;
      r_tx_done <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_SEND;
            r_cnt     <= '0;
            r_last    <= s_last;
            r_word    <= s_data >> 8;
            r_tx_data <= s_data[7:0];
            r_tx_en_n <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_SEND: begin
          if (r_cnt == CNT_LAST) begin
            if (w_accept) begin
              r_cnt     <= '0;
              r_last    <= s_last;
              r_word    <= s_data >> 8;
              r_tx_data <= s_data[7:0];
            end else if (r_last) begin
              r_state   <= S_DRAIN;
              r_cnt     <= '0;
              r_dcnt    <= DW'(1);
              r_tx_data <= 8'h00;
              r_tx_en_n <= 1'b1;
              r_tx_done <= (DRAIN == 1);
            end else begin
              // Frame stays open (busy held) while waiting for its next word.
              r_state   <= S_IDLE;
              r_cnt     <= '0;
              r_tx_data <= 8'h00;
              r_tx_en_n <= 1'b1;
            end
          end else begin
            r_cnt     <= r_cnt + CW'(1);
            r_tx_data <= r_word[7:0];
            r_word    <= r_word >> 8;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DCNT_LAST) begin
            r_state   <= S_IDLE;
            r_dcnt    <= '0;
            r_tx_done <= 1'b0;
            r_busy    <= 1'b0;
          end else begin
            r_dcnt    <= r_dcnt + DW'(1);
            r_tx_done <= (r_dcnt == DCNT_PRE);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/byte_stream_tx.md
# byte_stream_tx

Byte-serial transmitter that feeds the active-low-enabled byte delay line in the e203 self-test datapath. It accepts multi-byte words over a valid/ready handshake and emits them one byte per cycle with an active-low byte enable, zero-filling idle cycles. It tracks the downstream line's fixed latency and pulses `tx_done` when the final byte of a frame reaches the far end.

## Interface
- WORD_BYTES, 4, bytes per input word (>=1)
- DRAIN, 4, register stages in the downstream delay line (>=1)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_valid  in  1  input word valid
- s_ready  out  1  transmitter can accept a word this cycle
- s_data  in  8*WORD_BYTES  input word; byte 0 = s_data[7:0]
- s_last  in  1  word is the last of its frame
- tx_data  out  8  byte to downstream line
- tx_en_n  out  1  active-low byte enable; low = tx_data valid
- tx_done  out  1  one-cycle pulse: last frame byte now at downstream output
- busy  out  1  frame in progress (first word accepted, tx_done not yet pulsed)

## Operation
- States: IDLE, SEND, DRAIN. Byte counter `cnt` ranges 0..WORD_BYTES-1. `last_q` holds the latched `s_last`.
- IDLE: s_ready=1, tx_en_n=1, tx_data=0. On s_valid&&s_ready, latch s_data and s_last, set cnt=0, and go to SEND.
- SEND: tx_en_n=0, tx_data=byte[cnt], little-endian order.
  - cnt increments each cycle.
  - At cnt==WORD_BYTES-1, s_ready = !last_q. If a word is accepted then, reload, cnt=0, stay in SEND (no bubble).
  - Else if last_q, go to DRAIN.
  - Else go to IDLE with the frame still open; busy stays 1.
- DRAIN: tx_en_n=1, tx_data=0, s_ready=0. A drain counter runs DRAIN cycles. tx_done=1 in the final DRAIN cycle, then go to IDLE and busy falls.
- s_ready is low in SEND except at cnt==WORD_BYTES-1. It is also low while rst_n=0.
- Whenever tx_en_n=1, tx_data is forced to 0.
- busy rises the cycle after the first word of a frame is accepted.
- Widths:
  - cnt: clog2(WORD_BYTES) bits, minimum 1.
  - Drain counter: clog2(DRAIN+1) bits.
  - Counters never wrap outside their ranges.

## Timing
- All outputs except s_ready are registered. s_ready is decoded from registered state only, with no s_valid combinational path.
- Word accepted at edge T: byte k is presented in cycle T+1+k, for k = 0..WORD_BYTES-1.
- Back-to-back words: byte 0 of the next word follows byte WORD_BYTES-1 of the previous word in the immediately following cycle.
- Last byte of a frame presented in cycle L:
  - DRAIN occupies cycles L+1..L+DRAIN.
  - tx_done=1 in cycle L+DRAIN, coincident with that byte at the downstream line's output.
  - IDLE from L+DRAIN+1, with s_ready=1.
- Reset values after a clock edge with rst_n=0: state IDLE, tx_en_n=1, tx_data=0, tx_done=0, busy=0, s_ready=0 while rst_n=0, all counters 0.
- Reset mid-SEND or mid-DRAIN aborts the frame: tx_en_n=1 from the next cycle and no tx_done. Bytes already in the downstream line are not tracked.
- s_valid while s_ready=0 is ignored. s_data does not need to be held after acceptance.
- Single-word frame with WORD_BYTES=1 and DRAIN=1: accept at T, byte in T+1, tx_done in T+2, s_ready=1 in T+3.

## Test plan
- **Single frame:** WORD_BYTES=4, DRAIN=4, one word 0x44332211 with s_last=1 at T.
  - tx_en_n=0 with bytes 11,22,33,44 in T+1..T+4.
  - tx_done in T+8.
  - Downstream delay-line dout shows 11..44 in T+5..T+8.
- **Streaming:** two words 0xDDCCBBAA then 0x04030201 (last), s_valid held high.
  - 8 contiguous enabled bytes AA,BB,CC,DD,01,02,03,04.
  - s_ready high only in T+4.
  - Single tx_done 4 cycles after byte 04.
- **Gap inside frame:** first word with s_last=0, then s_valid low for 3 cycles, then the last word.
  - tx_en_n=1 and tx_data=0 during the gap.
  - busy=1 throughout.
  - Only one tx_done.
- **Back-pressure:** s_valid high during SEND cycles with cnt<3 and during DRAIN.
  - No acceptance: s_ready=0, data is not latched, and the byte stream is unchanged.
- **Reset mid-frame:** rst_n=0 for 1 cycle after byte 1 of a last word.
  - Next cycle: tx_en_n=1, tx_data=0, busy=0.
  - tx_done never pulses.
  - A subsequent frame transmits normally.
- **Edge parameters:** WORD_BYTES=1, DRAIN=1, word 0x5A last.
  - Byte 5A in T+1, tx_done in T+2, s_ready=1 in T+3.
